// File: rtl/regfile_wb_sched.sv
// Write-port scheduler and LU scoreboard for a 2R/1W register file.
// Arbitrates the single write port between pipeline writeback and the long-latency
// unit, buffers one displaced LU result, and stalls issue on hazards with LU writes in flight.
module regfile_wb_sched #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      wb_stall,
    input  logic                      lu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] lu_rd,
    input  logic [DATA_WIDTH-1:0]     lu_data,
    output logic                      lu_ready,
    input  logic                      iss_valid,
    input  logic [REG_ADDR_WIDTH-1:0] iss_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] iss_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
    input  logic                      iss_long,
    output logic                      iss_stall,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic                      busy
);

    localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;
    localparam int unsigned CntW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [NumRegs-1:0]        pending_q, pending_d;
    logic                      hold_full_q, hold_full_d;
    logic [REG_ADDR_WIDTH-1:0] hold_rd_q, hold_rd_d;
    logic [DATA_WIDTH-1:0]     hold_data_q, hold_data_d;
    logic [CntW-1:0]           starve_q, starve_d;
    logic                      rf_we_q, rf_we_d;
    logic                      rf_lu_q, rf_lu_d;   // current rf write came from the LU
    logic [REG_ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;

    logic wb_sel, hold_drain, lu_acc, lu_sel, lu_to_hold, iss_fire;

    // Handshakes, hazard detection and write-source arbitration.
    always_comb begin
        wb_stall   = hold_full_q && (starve_q >= Limit);
        lu_ready   = !hold_full_q;
        wb_sel     = wb_valid && !wb_stall;
        hold_drain = hold_full_q && !wb_sel;
        lu_acc     = lu_valid && lu_ready;
        lu_sel     = lu_acc && !wb_sel;
        lu_to_hold = lu_acc && wb_sel;
        iss_stall  = iss_valid &&
                     (pending_q[iss_rs1] | pending_q[iss_rs2] | pending_q[iss_rd]);
        iss_fire   = iss_valid && iss_long && !iss_stall && (iss_rd != '0);
        busy       = |pending_q;
        rf_we      = rf_we_q;
        rf_rd      = rf_rd_q;
        rf_wdata   = rf_wdata_q;
    end

    // Next state: write port, hold buffer, starvation counter, scoreboard.
    always_comb begin
        rf_rd_d     = rf_rd_q;
        rf_wdata_d  = rf_wdata_q;
        rf_we_d     = 1'b0;
        rf_lu_d     = 1'b0;
        if (wb_sel) begin
            rf_rd_d    = wb_rd;
            rf_wdata_d = wb_data;
            rf_we_d    = (wb_rd != '0);
        end else if (hold_full_q) begin
            rf_rd_d    = hold_rd_q;
            rf_wdata_d = hold_data_q;
            rf_we_d    = (hold_rd_q != '0);
            rf_lu_d    = 1'b1;
        end else if (lu_sel) begin
            rf_rd_d    = lu_rd;
            rf_wdata_d = lu_data;
            rf_we_d    = (lu_rd != '0);
            rf_lu_d    = 1'b1;
        end

        hold_full_d = hold_full_q;
        hold_rd_d   = hold_rd_q;
        hold_data_d = hold_data_q;
        if (lu_to_hold) begin
            hold_full_d = 1'b1;
            hold_rd_d   = lu_rd;
            hold_data_d = lu_data;
        end else if (hold_drain) begin
            hold_full_d = 1'b0;
        end

        starve_d = '0;
        if (hold_full_q && !hold_drain && (starve_q < Limit)) begin
            starve_d = starve_q + 1'b1;
        end

        // Clear first so a same-index set wins.
        pending_d = pending_q;
        if (rf_we_q && rf_lu_q) begin
            pending_d[rf_rd_q] = 1'b0;
        end
        if (iss_fire) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            hold_full_q <= 1'b0;
            hold_rd_q   <= '0;
            hold_data_q <= '0;
            starve_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_lu_q     <= 1'b0;
            rf_rd_q     <= '0;
            rf_wdata_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            hold_full_q <= hold_full_d;
            hold_rd_q   <= hold_rd_d;
            hold_data_q <= hold_data_d;
            starve_q    <= starve_d;
            rf_we_q     <= rf_we_d;
            rf_lu_q     <= rf_lu_d;
            rf_rd_q     <= rf_rd_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched (default parameters).
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        iss_valid;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_long;
    logic        iss_stall;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    regfile_wb_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_stall  (wb_stall),
        .lu_valid  (lu_valid),
        .lu_rd     (lu_rd),
        .lu_data   (lu_data),
        .lu_ready  (lu_ready),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_long  (iss_long),
        .iss_stall (iss_stall),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs may be changed right after, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_long = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #12;
        rst_n = 1;
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rf_rd got=%0d exp=0", rf_rd); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL reset_wb_stall got=%b exp=0", wb_stall); end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_lu_ready got=%b exp=1", lu_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL reset_iss_stall got=%b exp=0", iss_stall); end
    endtask

    task automatic test_wb_only();
        wb_valid = 1; wb_rd = 5'd3; wb_data = 32'hA5;
        tick();
        idle();
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL wb_rf_we got=%b exp=1", rf_we); end
        checks++; if (rf_rd !== 5'd3) begin errors++; $display("FAIL wb_rf_rd got=%0d exp=3", rf_rd); end
        checks++; if (rf_wdata !== 32'hA5) begin errors++; $display("FAIL wb_rf_wdata got=%h exp=a5", rf_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wb_busy got=%b exp=0", busy); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL wb_idle_we got=%b exp=0", rf_we); end
        checks++; if (rf_rd !== 5'd3 || rf_wdata !== 32'hA5) begin
            errors++; $display("FAIL wb_idle_hold got=%0d/%h exp=3/a5", rf_rd, rf_wdata);
        end
    endtask

    task automatic test_raw_hazard();
        iss_valid = 1; iss_long = 1; iss_rd = 5'd7;
        #1;
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL raw_issue_stall got=%b exp=0", iss_stall); end
        tick();
        iss_long = 0; iss_rd = 5'd1; iss_rs1 = 5'd7;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL raw_busy got=%b exp=1", busy); end
        checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL raw_stall got=%b exp=1", iss_stall); end
        // WAW against the in-flight destination also stalls.
        iss_rs1 = 5'd0; iss_rd = 5'd7;
        #1;
        checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL waw_stall got=%b exp=1", iss_stall); end
        iss_rd = 5'd1; iss_rs1 = 5'd7;
        lu_valid = 1; lu_rd = 5'd7; lu_data = 32'h77;
        tick();
        lu_valid = 0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h77) begin
            errors++; $display("FAIL raw_lu_write got=%b/%0d/%h exp=1/7/77", rf_we, rf_rd, rf_wdata);
        end
        checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_on_write got=%b exp=1", iss_stall); end
        tick();
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL raw_released got=%b exp=0", iss_stall); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL raw_busy_clear got=%b exp=0", busy); end
        idle();
    endtask

    task automatic test_collision();
        wb_valid = 1; wb_rd = 5'd2; wb_data = 32'h22;
        lu_valid = 1; lu_rd = 5'd9; lu_data = 32'h1234;
        #1;
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL col_lu_ready_pre got=%b exp=1", lu_ready); end
        tick();
        idle();
        #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd2 || rf_wdata !== 32'h22) begin
            errors++; $display("FAIL col_wb_first got=%b/%0d/%h exp=1/2/22", rf_we, rf_rd, rf_wdata);
        end
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL col_lu_ready_held got=%b exp=0", lu_ready); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h1234) begin
            errors++; $display("FAIL col_lu_second got=%b/%0d/%h exp=1/9/1234", rf_we, rf_rd, rf_wdata);
        end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL col_lu_ready_after got=%b exp=1", lu_ready); end
        tick();
    endtask

    task automatic test_starvation();
        int acc;
        acc = 0;
        wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h100;
        lu_valid = 1; lu_rd = 5'd10; lu_data = 32'hBEEF;
        tick();
        acc = 1;
        lu_valid = 0;
        wb_data = 32'h100 + acc;
        // Hold is now full; five cycles of contending writeback follow.
        for (int k = 1; k <= 5; k++) begin
            #1;
            checks++; if (wb_stall !== (k == 5)) begin
                errors++; $display("FAIL starve_stall_c%0d got=%b exp=%b", k, wb_stall, (k == 5));
            end
            tick();
            if (k == 5) begin
                checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_wdata !== 32'hBEEF) begin
                    errors++; $display("FAIL starve_drain got=%b/%0d/%h exp=1/10/beef", rf_we, rf_rd, rf_wdata);
                end
            end else begin
                checks++; if (rf_rd !== 5'd4 || rf_wdata !== 32'h100 + acc) begin
                    errors++; $display("FAIL starve_wb_c%0d got=%0d/%h exp=4/%h", k, rf_rd, rf_wdata, 32'h100 + acc);
                end
                acc++;
                wb_data = 32'h100 + acc;
            end
        end
        #1;
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL starve_resume_stall got=%b exp=0", wb_stall); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'h100 + acc) begin
            errors++; $display("FAIL starve_resume got=%b/%h exp=1/%h", rf_we, rf_wdata, 32'h100 + acc);
        end
        idle();
        tick();
    endtask

    task automatic test_zero_reg();
        lu_valid = 1; lu_rd = 5'd0; lu_data = 32'hDEAD;
        #1;
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL zero_lu_ready got=%b exp=1", lu_ready); end
        tick();
        idle();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zero_lu_we got=%b exp=0", rf_we); end
        wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hF00D;
        #1;
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL zero_wb_stall got=%b exp=0", wb_stall); end
        tick();
        idle();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zero_wb_we got=%b exp=0", rf_we); end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL zero_lu_ready_after got=%b exp=1", lu_ready); end
        iss_valid = 1; iss_long = 1; iss_rd = 5'd0;
        tick();
        idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_pending got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        wb_valid = 1; wb_rd = 5'd1; wb_data = 32'h11;
        lu_valid = 1; lu_rd = 5'd11; lu_data = 32'hBB;
        iss_valid = 1; iss_long = 1; iss_rd = 5'd5;
        tick();
        idle();
        #1;
        checks++; if (lu_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_setup got=%b/%b exp=0/1", lu_ready, busy);
        end
        #2;
        rst_n = 0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_async_we got=%b exp=0", rf_we); end
        #10;
        rst_n = 1;
        iss_valid = 1; iss_rs1 = 5'd5; iss_rd = 5'd1;
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_rf_we got=%b exp=0", rf_we); end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL mid_lu_ready got=%b exp=1", lu_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL mid_iss_stall got=%b exp=0", iss_stall); end
        idle();
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_raw_hazard();
        test_collision();
        test_starvation();
        test_zero_reg();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
